// File: rtl/cdc_arb_pkg.sv
// Shared definitions for the usb_cdc IN-stream arbiter: state encoding,
// tag nibble, output-slot payload and width helpers.
package cdc_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HEADER = 2'd1;
   localparam logic [1:0] ST_BURST  = 2'd2;

   localparam logic [3:0] TAG_NIBBLE = 4'hA;

   // One byte slot towards usb_cdc.
   typedef struct packed {
      logic       valid;
      logic [7:0] data;
   } out_slot_t;

   // Burst counter must hold 0..max_burst inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_burst);
      return 32'($clog2(max_burst + 1));
   endfunction

   function automatic int unsigned idx_width(input int unsigned n_req);
      return (n_req < 2) ? 32'd1 : 32'($clog2(n_req));
   endfunction

endpackage

// File: rtl/cdc_in_arbiter_rr_pick.sv
// Round-robin search: first set request bit strictly after 'last',
// wrapping modulo N_REQ.
module rr_pick
   import cdc_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   always_comb begin
      logic [IDX_W-1:0] cand;
      int unsigned      pos;
      idx_o   = '0;
      found_o = 1'b0;
      cand    = '0;
      pos     = 0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         pos  = (32'(last_i) + i) % N_REQ;
         cand = IDX_W'(pos);
         if (!found_o && req_i[cand]) begin
            idx_o   = cand;
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdc_in_arbiter.sv
// Round-robin arbiter sharing the usb_cdc IN byte stream between N_REQ
// producers, with burst locking and an optional channel tag byte.
module cdc_in_arbiter
   import cdc_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned MAX_BURST = 8,
   parameter bit          TAG_EN    = 1'b0
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic [8*N_REQ-1:0] req_data_i,
   input  logic [N_REQ-1:0]   req_valid_i,
   output logic [N_REQ-1:0]   req_ready_o,
   output logic [7:0]         in_data_o,
   output logic               in_valid_o,
   input  logic               in_ready_i,
   output logic [N_REQ-1:0]   grant_o,
   output logic               busy_o
);

   localparam int unsigned      IDX_W   = idx_width(N_REQ);
   localparam int unsigned      CNT_W   = cnt_width(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   logic [1:0]       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_q,  last_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   out_slot_t        out_q,   out_d;
   logic             busy_q,  busy_d;

   logic             slot_free;
   logic             cur_valid;
   logic [7:0]       cur_data;
   logic [CNT_W-1:0] cnt_inc;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i   (req_valid_i),
      .last_i  (last_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   // last_q doubles as the index of the current grant holder.
   always_comb begin
      cur_data = 8'h00;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (last_q == IDX_W'(k)) cur_data = req_data_i[8*k +: 8];
      end
   end

   assign slot_free = ~out_q.valid | in_ready_i;
   assign cur_valid = req_valid_i[last_q];
   assign cnt_inc   = cnt_q + CNT_W'(1);

   always_comb begin
      req_ready_o = '0;
      if (state_q == ST_BURST && slot_free) req_ready_o = grant_q & req_valid_i;
   end

   // Next-state, grant and output-slot logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      if (slot_free) out_d.valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               last_d            = pick_idx;
               cnt_d             = '0;
               state_d           = TAG_EN ? ST_HEADER : ST_BURST;
            end
         end
         ST_HEADER: begin
            if (slot_free) begin
               out_d.valid = 1'b1;
               out_d.data  = {TAG_NIBBLE, 4'(last_q)};
               state_d     = ST_BURST;
            end
         end
         ST_BURST: begin
            if (slot_free) begin
               if (cur_valid) begin
                  out_d.valid = 1'b1;
                  out_d.data  = cur_data;
                  cnt_d       = cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     state_d = ST_IDLE;
                     grant_d = '0;
                  end
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(N_REQ - 1);
         cnt_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   assign in_valid_o = out_q.valid;
   assign in_data_o  = out_q.data;
   assign grant_o    = grant_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Bench for cdc_in_arbiter: three configurations (burst 8 / burst 2 / tagged)
// driven from per-requester byte queues against a round-robin stream model.
module tb_cdc_in_arbiter;

   localparam int N = 4;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rstn      [3];
   logic [8*N-1:0] req_data  [3];
   logic [N-1:0]   req_valid [3];
   logic [N-1:0]   req_ready [3];
   logic [7:0]     in_data   [3];
   logic           in_valid  [3];
   logic           in_ready  [3];
   logic [N-1:0]   grant     [3];
   logic           busy      [3];

   // Model configuration per instance.
   int mb [3] = '{8, 2, 8};
   bit tg [3] = '{1'b0, 1'b0, 1'b1};
   int model_last [3];

   logic [7:0]   rq [N][$];
   logic [7:0]   exp_q[$];
   logic [7:0]   got_q[$];
   bit           obs_v[$];
   logic [7:0]   obs_d[$];
   logic [N-1:0] obs_g[$];
   bit           obs_b[$];

   cdc_in_arbiter #(.N_REQ(4), .MAX_BURST(8), .TAG_EN(1'b0)) dut_a (
      .clk_i(clk), .rstn_i(rstn[0]), .req_data_i(req_data[0]), .req_valid_i(req_valid[0]),
      .req_ready_o(req_ready[0]), .in_data_o(in_data[0]), .in_valid_o(in_valid[0]),
      .in_ready_i(in_ready[0]), .grant_o(grant[0]), .busy_o(busy[0]));

   cdc_in_arbiter #(.N_REQ(4), .MAX_BURST(2), .TAG_EN(1'b0)) dut_b (
      .clk_i(clk), .rstn_i(rstn[1]), .req_data_i(req_data[1]), .req_valid_i(req_valid[1]),
      .req_ready_o(req_ready[1]), .in_data_o(in_data[1]), .in_valid_o(in_valid[1]),
      .in_ready_i(in_ready[1]), .grant_o(grant[1]), .busy_o(busy[1]));

   cdc_in_arbiter #(.N_REQ(4), .MAX_BURST(8), .TAG_EN(1'b1)) dut_c (
      .clk_i(clk), .rstn_i(rstn[2]), .req_data_i(req_data[2]), .req_valid_i(req_valid[2]),
      .req_ready_o(req_ready[2]), .in_data_o(in_data[2]), .in_valid_o(in_valid[2]),
      .in_ready_i(in_ready[2]), .grant_o(grant[2]), .busy_o(busy[2]));

   // Each requester presents the head of its queue whenever it is non-empty.
   task automatic drive_inputs(input int d);
      for (int k = 0; k < N; k++) begin
         req_valid[d][k]       = (rq[k].size() > 0);
         req_data[d][8*k +: 8] = (rq[k].size() > 0) ? rq[k][0] : 8'h00;
      end
   endtask

   // Expected stream: round robin over non-empty queues, each turn an optional
   // tag then up to MAX_BURST bytes.
   task automatic build_expected(input int d);
      logic [7:0] cq [N][$];
      int j, nb;
      bit any;
      exp_q.delete();
      for (int k = 0; k < N; k++) cq[k] = rq[k];
      any = 1'b1;
      while (any) begin
         any = 1'b0;
         for (int k = 0; k < N; k++) if (cq[k].size() > 0) any = 1'b1;
         if (any) begin
            j = 0;
            for (int i = 1; i <= N; i++) begin
               j = (model_last[d] + i) % N;
               if (cq[j].size() > 0) break;
            end
            if (tg[d]) exp_q.push_back(8'(8'hA0 | j));
            nb = (cq[j].size() < mb[d]) ? cq[j].size() : mb[d];
            repeat (nb) exp_q.push_back(cq[j].pop_front());
            model_last[d] = j;
         end
      end
   endtask

   // bp: 0 = always ready, 1 = random ready, 2 = ready low for observations 4..8.
   task automatic run_stream(input int d, input int bp);
      logic [N-1:0] hs;
      logic [7:0]   prev_data, tmp;
      bit           prev_stall, done, empty;
      int           n;
      build_expected(d);
      got_q.delete(); obs_v.delete(); obs_d.delete(); obs_g.delete(); obs_b.delete();
      drive_inputs(d);
      in_ready[d] = 1'b1;
      prev_stall = 1'b0; prev_data = 8'h00; done = 1'b0; n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         obs_v.push_back(in_valid[d]); obs_d.push_back(in_data[d]);
         obs_g.push_back(grant[d]);    obs_b.push_back(busy[d]);
         checks++;
         if (!$onehot0(req_ready[d]) || ((req_ready[d] & ~grant[d]) != '0)) begin
            failures++;
            $display("FAIL ready_onehot: req_ready=%b grant=%b", req_ready[d], grant[d]);
         end
         checks++;
         if (!$onehot0(grant[d]) || (busy[d] !== (|grant[d]))) begin
            failures++;
            $display("FAIL grant_busy: grant=%b busy=%b", grant[d], busy[d]);
         end
         if (in_valid[d] && !in_ready[d]) begin
            checks++;
            if (req_ready[d] !== '0) begin
               failures++;
               $display("FAIL stall_ready: req_ready=%b want 0", req_ready[d]);
            end
         end
         if (prev_stall) begin
            checks++;
            if (in_valid[d] !== 1'b1 || in_data[d] !== prev_data) begin
               failures++;
               $display("FAIL hold: valid=%b data=%h want 1/%h", in_valid[d], in_data[d], prev_data);
            end
         end
         if (bp == 2 && n >= 4 && n <= 8) begin
            checks++;
            if (in_valid[d] !== 1'b1 || req_ready[d] !== '0) begin
               failures++;
               $display("FAIL bp_window: valid=%b req_ready=%b want 1/0", in_valid[d], req_ready[d]);
            end
         end
         hs = req_ready[d] & req_valid[d];
         if (in_valid[d] && in_ready[d]) got_q.push_back(in_data[d]);
         prev_stall = in_valid[d] && !in_ready[d];
         prev_data  = in_data[d];
         empty = 1'b1;
         for (int k = 0; k < N; k++) if (rq[k].size() > 0) empty = 1'b0;
         if (empty && !in_valid[d] && !busy[d]) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) if (hs[k]) tmp = rq[k].pop_front();
            drive_inputs(d);
            n++;
            if (bp == 1)      in_ready[d] = ($urandom_range(0, 3) != 0);
            else if (bp == 2) in_ready[d] = !(n >= 4 && n <= 8);
            else              in_ready[d] = 1'b1;
         end
      end
      in_ready[d] = 1'b1;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL timeout: dut=%0d still busy after %0d cycles", d, n);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL stream_len: dut=%0d got %0d bytes want %0d", d, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL stream_byte: dut=%0d idx=%0d got %h want %h", d, i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         rstn[d] = 1'b0; req_valid[d] = '0; req_data[d] = '0; in_ready[d] = 1'b1;
         model_last[d] = N - 1;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (in_valid[d] !== 1'b0 || in_data[d] !== 8'h00 || req_ready[d] !== '0 ||
             grant[d] !== '0 || busy[d] !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: dut=%0d valid=%b data=%h ready=%b grant=%b busy=%b want all 0",
                     d, in_valid[d], in_data[d], req_ready[d], grant[d], busy[d]);
         end
         rstn[d] = 1'b1;
      end
   endtask

   task automatic test_basic();
      rq[0] = '{8'h11, 8'h22, 8'h33};
      run_stream(0, 0);
      checks++;
      if (obs_g.size() < 5) begin
         failures++;
         $display("FAIL basic_len: got %0d observations want >=5", obs_g.size());
      end else begin
         checks++;
         if (obs_g[0] !== 4'b0001 || obs_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL basic_arb: grant=%b valid=%b want 0001/0", obs_g[0], obs_v[0]);
         end
         for (int i = 1; i <= 3; i++) begin
            checks++;
            if (obs_v[i] !== 1'b1 || obs_d[i] !== 8'(8'h11 * i) || obs_g[i] !== 4'b0001) begin
               failures++;
               $display("FAIL basic_byte%0d: valid=%b data=%h grant=%b want 1/%h/0001",
                        i, obs_v[i], obs_d[i], obs_g[i], 8'(8'h11 * i));
            end
         end
         checks++;
         if (obs_g[4] !== 4'b0000 || obs_v[4] !== 1'b0 || obs_b[4] !== 1'b0) begin
            failures++;
            $display("FAIL basic_end: grant=%b valid=%b busy=%b want 0/0/0", obs_g[4], obs_v[4], obs_b[4]);
         end
      end
   endtask

   task automatic test_rr_cap();
      logic [N-1:0] seg_g[$];
      int gaps[$];
      int zrun;
      for (int k = 0; k < N; k++)
         for (int b = 0; b < 3; b++) rq[k].push_back(8'((k << 4) | b));
      run_stream(1, 0);
      zrun = 0;
      for (int i = 0; i < obs_g.size(); i++) begin
         if (obs_g[i] == '0) zrun++;
         else begin
            if (i == 0 || obs_g[i-1] != obs_g[i]) begin
               if (seg_g.size() > 0) gaps.push_back(zrun);
               seg_g.push_back(obs_g[i]);
            end
            zrun = 0;
         end
      end
      checks++;
      if (seg_g.size() < 5) begin
         failures++;
         $display("FAIL rr_segments: got %0d grants want >=5", seg_g.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (seg_g[i] !== 4'(1 << (i % 4))) begin
               failures++;
               $display("FAIL rr_order%0d: grant=%b want %b", i, seg_g[i], 4'(1 << (i % 4)));
            end
         end
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (gaps[i] != 1) begin
               failures++;
               $display("FAIL rr_gap%0d: idle cycles=%0d want 1", i, gaps[i]);
            end
         end
      end
   endtask

   task automatic test_tag();
      rq[2] = '{8'h5A};
      run_stream(2, 0);
      checks++;
      if (obs_v.size() < 4 || obs_v[1] !== 1'b1 || obs_d[1] !== 8'hA2 ||
          obs_v[2] !== 1'b1 || obs_d[2] !== 8'h5A) begin
         failures++;
         $display("FAIL tag_timing: obs1=%b/%h obs2=%b/%h want 1/a2 1/5a",
                  obs_v[1], obs_d[1], obs_v[2], obs_d[2]);
      end
   endtask

   task automatic test_backpressure();
      for (int b = 0; b < 6; b++) rq[1].push_back(8'(8'hC0 + b));
      run_stream(0, 2);
   endtask

   task automatic test_two_req();
      for (int b = 0; b < 20; b++) begin
         rq[1].push_back(8'(8'h10 + b));
         rq[3].push_back(8'(8'h30 + b));
      end
      run_stream(0, 0);
   endtask

   task automatic test_random();
      int d, len;
      for (int it = 0; it < 6; it++) begin
         d = it % 3;
         for (int k = 0; k < N; k++) begin
            len = $urandom_range(0, 12);
            repeat (len) rq[k].push_back(8'($urandom));
         end
         run_stream(d, 1);
      end
   endtask

   task automatic test_reset_mid();
      for (int b = 0; b < 10; b++) rq[2].push_back(8'(8'h20 + b));
      drive_inputs(0);
      in_ready[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      in_ready[0] = 1'b0;
      checks++;
      if (in_valid[0] !== 1'b1 || grant[0] !== 4'b0100) begin
         failures++;
         $display("FAIL mid_setup: valid=%b grant=%b want 1/0100", in_valid[0], grant[0]);
      end
      @(posedge clk);
      #2;
      rstn[0] = 1'b0;
      #1;
      checks++;
      if (in_valid[0] !== 1'b0 || grant[0] !== '0 || req_ready[0] !== '0 ||
          busy[0] !== 1'b0 || in_data[0] !== 8'h00) begin
         failures++;
         $display("FAIL async_reset: valid=%b grant=%b ready=%b busy=%b data=%h want all 0",
                  in_valid[0], grant[0], req_ready[0], busy[0], in_data[0]);
      end
      rq[2].delete();
      drive_inputs(0);
      in_ready[0] = 1'b1;
      @(negedge clk);
      rstn[0] = 1'b1;
      model_last[0] = N - 1;
      rq[0] = '{8'h01, 8'h02};
      rq[2] = '{8'h21, 8'h22};
      run_stream(0, 0);
      checks++;
      if (obs_g[0] !== 4'b0001) begin
         failures++;
         $display("FAIL post_reset_grant: grant=%b want 0001", obs_g[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rr_cap();
      test_tag();
      test_backpressure();
      test_two_req();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
